// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word-array responder with wait states.
// Optional MEM_ERR_EN: flags misaligned, out-of-range and undefined requests.
module mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_accept;
  logic        w_access;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_f3;

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  logic          w_f3_ok;
  logic [2:0]    w_f3;
  logic [1:0]    w_lane;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic          w_wr;
  logic [3:0]    w_be;
  logic [31:0]   w_wd;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld;

  // State and wait counter; reset discards any in-flight request.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, wait countdown and handshake outputs.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    w_accept  = 1'b0;
    w_access  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept  = 1'b1;
          w_cnt_nxt = 4'(WAIT_CYCLES);
          w_next    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Capture the request so inputs may change after accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_f3    <= req_funct3;
    end
  end

  // Size decode: stores only know B/H/W; unknown codes fall back to W.
  always_comb begin
    w_f3_ok = 1'b0;
    unique case (r_f3)
      3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
      3'b100, 3'b101:         w_f3_ok = !r_we;
      default:                w_f3_ok = 1'b0;
    endcase
  end

  assign w_f3  = w_f3_ok ? r_f3 : 3'b010;
  assign w_idx = r_addr[AW+1:2];

`ifdef MEM_ERR_EN
  assign w_lane = r_addr[1:0];
  assign w_err  = !w_f3_ok
               || (w_f3[1:0] == 2'b01 && r_addr[0])
               || (w_f3[1:0] == 2'b10 && r_addr[1:0] != 2'b00)
               || (|r_addr[31:AW+2]);
`else
  assign w_lane = (w_f3[1:0] == 2'b00) ? r_addr[1:0] :
                  (w_f3[1:0] == 2'b01) ? {r_addr[1], 1'b0} :
                  2'b00;
  assign w_err  = 1'b0;
`endif

  // Byte enables and lane-replicated store data.
  always_comb begin
    w_be = 4'b1111;
    w_wd = r_wdata;
    unique case (w_f3[1:0])
      2'b00: begin
        w_be = 4'b0001 << w_lane;
        w_wd = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = r_wdata;
      end
    endcase
  end

  assign w_wr   = w_access && !resetn && r_we && !w_err;
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[8*w_lane +: 8];
  assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

  // Load lane select with sign or zero extension.
  always_comb begin
    w_ld = w_word;
    unique case (w_f3)
      3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld = {24'd0, w_byte};
      3'b101:  w_ld = {16'd0, w_half};
      default: w_ld = w_word;
    endcase
  end

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  // Response data register, updated only at the access edge.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_rdata <= 32'd0;
    end else if (w_access) begin
      r_rdata <= (r_we || w_err) ? 32'd0 : w_ld;
    end
  end

  assign rsp_rdata = r_rdata;

`ifdef MEM_ERR_EN
  logic r_err;

  // Error qualifier captured alongside the response data.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_err <= 1'b0;
    end else if (w_access) begin
      r_err <= w_err;
    end
  end

  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: three responders (WAIT_CYCLES 1, 0, 3) on shared stimulus,
// with per-instance expected-response queues checked by a monitor.
module tb_mem_responder;

  localparam int NDUT = 3;
  localparam int WL [NDUT] = '{1, 0, 3};

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;

  logic        rdy [NDUT];
  logic        rv  [NDUT];
  logic [31:0] rd  [NDUT];
  logic        re  [NDUT];

  int          n_chk  = 0;
  int          n_pass = 0;
  int unsigned cyc    = 0;

  logic [31:0] g_exp_rdata;
  logic        g_exp_err;

`ifdef MEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    exp_t q[$];

    mem_responder #(
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES(WL[g])
    ) u_dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (rdy[g]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_funct3(req_funct3),
      .rsp_valid (rv[g]),
      .rsp_rdata (rd[g]),
      .rsp_err   (re[g])
    );

    always @(posedge clk) begin
      if (resetn) q.delete();
      else if (rdy[g] && req_valid)
        q.push_back('{g_exp_rdata, g_exp_err, 32'(cyc)});
    end

    always @(negedge clk) begin
      exp_t e;
      if (!resetn) begin
        if (rv[g]) begin
          if (q.size() == 0) begin
            n_chk++;
            $display("FAIL d%0d unexpected_rsp: rdata %h", g, rd[g]);
          end else begin
            e = q.pop_front();
            check($sformatf("d%0d rdata", g), rd[g], e.rdata);
            check($sformatf("d%0d err", g), 32'(re[g]), 32'(e.err));
            check($sformatf("d%0d latency", g), cyc - e.acc,
                  32'(WL[g] + 2));
            check($sformatf("d%0d ready_in_resp", g), 32'(rdy[g]), 0);
          end
        end else if (q.size() != 0) begin
          check($sformatf("d%0d ready_in_busy", g), 32'(rdy[g]), 0);
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    req_valid = 1'b0;
    do begin
      @(negedge clk);
      k++;
    end while (!(rdy[0] && rdy[1] && rdy[2]) && k < 60);
    if (k >= 60) begin
      n_chk++;
      $display("FAIL idle_timeout: got busy want idle");
    end
  endtask

  task automatic req(input logic we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] xd, input logic xe);
    g_exp_rdata = xd;
    g_exp_err   = xe;
    req_we      = we;
    req_funct3  = f3;
    req_addr    = a;
    req_wdata   = wd;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'b111;
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn      = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = 32'd0;
    req_wdata   = 32'd0;
    req_funct3  = 3'b010;
    g_exp_rdata = 32'd0;
    g_exp_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("d%0d rst_ready", i), 32'(rdy[i]), 1);
      check($sformatf("d%0d rst_valid", i), 32'(rv[i]), 0);
      check($sformatf("d%0d rst_rdata", i), rd[i], 0);
      check($sformatf("d%0d rst_err", i), 32'(re[i]), 0);
    end
    resetn = 1'b0;
    @(negedge clk);

    req(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    req(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    req(1, 3'b000, 32'h11, 32'hAABBCC55, 32'h0, 0);
    req(0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0);
    req(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    req(0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 0);
    req(0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0);
    req(0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0);

    req(1, 3'b010, 32'h14, 32'h11223344, 32'h0, 0);
    req(1, 3'b001, 32'h16, 32'hFFFF8001, 32'h0, 0);
    req(0, 3'b010, 32'h14, 32'h0, 32'h80013344, 0);
    req(0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 0);
    req(0, 3'b000, 32'h14, 32'h0, 32'h00000044, 0);
    req(0, 3'b000, 32'h17, 32'h0, 32'hFFFFFF80, 0);
    req(0, 3'b101, 32'h14, 32'h0, 32'h00003344, 0);

    req(1, 3'b010, 32'h20, 32'h0, 32'h0, 0);
    g_exp_rdata = 32'h0;
    g_exp_err   = 1'b0;
    req_we      = 1'b1;
    req_funct3  = 3'b010;
    req_addr    = 32'h20;
    req_wdata   = 32'h12345678;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    resetn    = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    wait_idle();
    req(0, 3'b010, 32'h20, 32'h0, 32'h00000000, 0);
    req(0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0);
    req(0, 3'b010, 32'h14, 32'h0, 32'h80013344, 0);

    req(1, 3'b010, 32'h20, 32'hA5A50F0F, 32'h0, 0);
    req(1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 0);
    if (ERR) begin
      req(0, 3'b010, 32'h22, 32'h0, 32'h0, 1);
      req(0, 3'b001, 32'h23, 32'h0, 32'h0, 1);
      req(0, 3'b011, 32'h20, 32'h0, 32'h0, 1);
      req(0, 3'b001, 32'h22, 32'h0, 32'hFFFFA5A5, 0);
      req(1, 3'b010, 32'h1000, 32'h0BADBEEF, 32'h0, 1);
      req(0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 0);
      req(1, 3'b101, 32'h20, 32'h01020304, 32'h0, 1);
      req(0, 3'b010, 32'h20, 32'h0, 32'hA5A50F0F, 0);
    end else begin
      req(0, 3'b010, 32'h22, 32'h0, 32'hA5A50F0F, 0);
      req(0, 3'b001, 32'h23, 32'h0, 32'hFFFFA5A5, 0);
      req(0, 3'b011, 32'h20, 32'h0, 32'hA5A50F0F, 0);
      req(1, 3'b010, 32'h1000, 32'h0BADBEEF, 32'h0, 0);
      req(0, 3'b010, 32'h0, 32'h0, 32'h0BADBEEF, 0);
      req(1, 3'b101, 32'h4, 32'h01020304, 32'h0, 0);
      req(0, 3'b010, 32'h4, 32'h0, 32'h01020304, 0);
    end

    g_exp_rdata = 32'hDEAD55EF;
    g_exp_err   = 1'b0;
    req_we      = 1'b0;
    req_funct3  = 3'b010;
    req_addr    = 32'h10;
    req_wdata   = 32'h0;
    req_valid   = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    wait_idle();

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's data and instruction port.
- Accepts one request at a time (address, write data, write enable, RISC-V funct3 size code) and serves it from an internal word array after a programmable number of wait states.
- Returns a one-cycle response pulse with sign- or zero-extended load data.
- Handles sub-word byte-lane placement for SB/SH/SW and LB/LH/LW/LBU/LHU.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, ≥4).
- WAIT_CYCLES, 1, extra wait states between accept and access (0..15).

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  synchronous active-high reset (asserted = 1, sampled on clk rising edge).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; value to write sits in low bits.
- req_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  error qualifier, valid with rsp_valid (MEM_ERR_EN only).

Behaviour:
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, wait counter 0.
- Reset does not clear array contents.
- FSM states:
  - IDLE: req_ready = 1. If req_valid is high at an edge, latch we/addr/wdata/funct3, load cnt = WAIT_CYCLES, go to BUSY.
  - BUSY: req_ready = 0. If cnt != 0, decrement cnt. If cnt == 0, perform the access at this edge and go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, then go to IDLE.
- No back-to-back accept; a new request is accepted no earlier than the edge that leaves RESP.
- Latency: if accept happens at edge E0, the access edge is E0+WAIT_CYCLES+1, and rsp_valid is high in the cycle that follows that edge.
- Input hold: req_* may change freely after the accept edge; the latched copies are used.
- Word index is addr[AW+1:2], with AW = log2(DEPTH_WORDS). Lane is addr[1:0].
- Stores:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- Loads:
  - Select the addressed byte or half from the stored word.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- rsp_rdata:
  - Registered at the access edge.
  - Holds its value until the next access edge.
  - Stores set it to 0.
- Read-during-write cannot occur (single outstanding request).
- Reset mid-operation: an in-flight request is discarded and no response is issued.
  - If resetn is high at the access edge, the write is not committed.
  - A write committed at an earlier edge stays.
- Undefined funct3 (011, 110, 111) or store funct3 > 010: behaviour set by MEM_ERR_EN.

Optional Feature:
- Macro: MEM_ERR_EN.
- Defined:
  - The following are errors: misaligned H (addr[0] = 1), misaligned W (addr[1:0] != 0), address ≥ DEPTH_WORDS*4, or an undefined funct3.
  - On error: no array write, rsp_rdata = 0, rsp_err = 1 with rsp_valid.
  - rsp_err is 0 otherwise.
- Undefined:
  - rsp_err is tied 0.
  - Low address bits are masked to size alignment (H clears bit 0, W clears bits 1:0).
  - Upper address bits beyond AW+1 are ignored (wrap-around).
  - Undefined funct3 is treated as W (010).

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rdata 0xDEADBEEF; rsp_valid exactly 2 edges after each accept (WAIT_CYCLES=1); req_ready low in BUSY and RESP.
- After word 0x10 = 0xDEADBEEF: SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF; LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x12 → 0x0000DEAD.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: LW → rsp_valid 1 and 4 edges after accept respectively; req_valid held high continuously → next accept only at the edge leaving RESP.
- Reset during BUSY of SW 0x20 data 0x12345678 (word previously 0): no rsp_valid; after reset LW 0x20 → 0x00000000; earlier stored words unchanged.
- MEM_ERR_EN defined: LW 0x22 → rsp_err 1, rdata 0; SW 0x1000 with DEPTH_WORDS=1024 → rsp_err 1, no write.
- MEM_ERR_EN undefined: LW 0x22 → reads word 0x20 with rsp_err 0; addr 0x1000 wraps to word 0.
